// File: rtl/fft_twiddle_mult_pkg.sv
// Shared FFT package: sample type, fixed-point widths and the twiddle table
// walked by the twiddle generator (W8^k, k = 0..3, Q2.14).
package fft_twiddle_mult_pkg;

    localparam int DATA_W  = 16;
    localparam int TW_FRAC = 14;
    localparam int TW_N    = 4;

    typedef struct packed {
        logic signed [DATA_W-1:0] data_r;
        logic signed [DATA_W-1:0] data_i;
    } FFT_DATA_SAMPLE;

    localparam FFT_DATA_SAMPLE TW_TABLE [TW_N] = '{
        '{data_r:  16'sd16384, data_i:  16'sd0},
        '{data_r:  16'sd11585, data_i: -16'sd11585},
        '{data_r:  16'sd0,     data_i: -16'sd16384},
        '{data_r: -16'sd11585, data_i: -16'sd11585}
    };

endpackage

// File: rtl/fft_twiddle_mult_if.sv
// Handshake bundle between the butterfly/twiddle generator, the twiddle
// multiplier and its downstream consumer.
interface fft_twiddle_mult_if
    import fft_twiddle_mult_pkg::*;
();

    logic           in_valid;
    logic           in_ready;
    FFT_DATA_SAMPLE in_data;
    FFT_DATA_SAMPLE tw_data;
    logic           tw_pop;
    logic           out_valid;
    logic           out_ready;
    FFT_DATA_SAMPLE out_data;
    logic           ovf;

    modport master (
        output in_valid, in_data, tw_data, out_ready,
        input  in_ready, tw_pop, out_valid, out_data, ovf
    );

    modport slave (
        input  in_valid, in_data, tw_data, out_ready,
        output in_ready, tw_pop, out_valid, out_data, ovf
    );

endinterface

// File: rtl/fft_cmult_core.sv
// Complex multiply datapath for the twiddle multiplier: partial products,
// add/sub, round half up and fit to DATA_W.
// FFT_MULT_SAT_EN defined: saturate and keep a sticky overflow flag.
// FFT_MULT_SAT_EN undefined: two's-complement wrap, ovf held at 0.
module fft_cmult_core
    import fft_twiddle_mult_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           ld_p2,
    input  FFT_DATA_SAMPLE a_p0,
    input  FFT_DATA_SAMPLE w_p0,
    output FFT_DATA_SAMPLE y_p2,
    output logic           ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 1;

`ifdef FFT_MULT_SAT_EN
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - SUM_W'(1);
`endif

    function automatic logic signed [SUM_W-1:0] round_half_up(input logic signed [SUM_W-1:0] x);
        logic signed [SUM_W-1:0] biased;
        biased = x + SUM_W'(1 << (TW_FRAC - 1));
        return biased >>> TW_FRAC;
    endfunction

    function automatic logic signed [DATA_W-1:0] fit(input logic signed [SUM_W-1:0] x);
`ifdef FFT_MULT_SAT_EN
        if (x > MAX_V) return MAX_V[DATA_W-1:0];
        if (x < MIN_V) return MIN_V[DATA_W-1:0];
`endif
        return x[DATA_W-1:0];
    endfunction

    logic signed [PROD_W-1:0] rr_p1, ii_p1, ri_p1, ir_p1;
    logic signed [SUM_W-1:0]  re_p1, im_p1, re_rnd, im_rnd;

    // Stage 2 boundary: register the four partial products
    always_ff @(posedge clk) begin
        if (en) begin
            rr_p1 <= PROD_W'($signed(a_p0.data_r)) * PROD_W'($signed(w_p0.data_r));
            ii_p1 <= PROD_W'($signed(a_p0.data_i)) * PROD_W'($signed(w_p0.data_i));
            ri_p1 <= PROD_W'($signed(a_p0.data_r)) * PROD_W'($signed(w_p0.data_i));
            ir_p1 <= PROD_W'($signed(a_p0.data_i)) * PROD_W'($signed(w_p0.data_r));
        end
    end

    assign re_p1  = SUM_W'(rr_p1) - SUM_W'(ii_p1);
    assign im_p1  = SUM_W'(ri_p1) + SUM_W'(ir_p1);
    assign re_rnd = round_half_up(re_p1);
    assign im_rnd = round_half_up(im_p1);

    // Stage 3 boundary: fit the rounded result; only valid samples load so the output holds between samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p2 <= '0;
        end else if (ld_p2) begin
            y_p2.data_r <= fit(re_rnd);
            y_p2.data_i <= fit(im_rnd);
        end
    end

`ifdef FFT_MULT_SAT_EN
    logic clamp;
    assign clamp = (re_rnd > MAX_V) || (re_rnd < MIN_V) ||
                   (im_rnd > MAX_V) || (im_rnd < MIN_V);

    // Sticky overflow, set as a clamped sample enters the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ld_p2 && clamp) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/fft_twiddle_mult.sv
// Pipelined twiddle multiplier: out = in_data * tw_data, 3-cycle latency,
// one sample per cycle. Pops one twiddle from the generator per accepted
// sample so the generator order tracks the data stream.
// Optional macro FFT_MULT_SAT_EN: saturating output with sticky ovf.
module fft_twiddle_mult
    import fft_twiddle_mult_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    fft_twiddle_mult_if.slave bus
);

    logic           en;
    logic           accept;
    logic           ld_p2;
    logic           vld_p0, vld_p1, vld_p2;
    FFT_DATA_SAMPLE a_p0, w_p0;

    // Whole pipeline moves as one; bubbles are not collapsed
    assign en            = bus.out_ready | ~vld_p2;
    assign accept        = bus.in_valid & en;
    assign ld_p2         = en & vld_p1;
    assign bus.in_ready  = en;
    assign bus.tw_pop    = accept;
    assign bus.out_valid = vld_p2;

    // Stage valids; reset drops every in-flight sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1 boundary: capture the sample and the twiddle offered alongside it
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= bus.in_data;
            w_p0 <= bus.tw_data;
        end
    end

    fft_cmult_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .ld_p2 (ld_p2),
        .a_p0  (a_p0),
        .w_p0  (w_p0),
        .y_p2  (bus.out_data),
        .ovf   (bus.ovf)
    );

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Testbench for fft_twiddle_mult: directed cases plus randomized streams
// checked against a behavioural complex-multiply model and a scoreboard.
module tb_fft_twiddle_mult;
    import fft_twiddle_mult_pkg::*;

`ifdef FFT_MULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        FFT_DATA_SAMPLE d;
        bit             clip;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_twiddle_mult_if bus ();

    fft_twiddle_mult dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Twiddle generator stand-in: walks the table, advanced by tw_pop
    bit             use_gen = 1'b0;
    FFT_DATA_SAMPLE tw_direct;
    int             gen_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) gen_idx <= 0;
        else if (bus.tw_pop) gen_idx <= (gen_idx + 1) % TW_N;
    end
    always_comb bus.tw_data = use_gen ? TW_TABLE[gen_idx] : tw_direct;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Scale a full-precision value back to DATA_W: round half up, then clamp or wrap
    function automatic longint scale(input longint x, output bit clip);
        longint div, q, hi, lo, span;
        div  = longint'(1) << TW_FRAC;
        hi   = (longint'(1) << (DATA_W - 1)) - 1;
        lo   = -hi - 1;
        span = hi - lo + 1;
        q    = x + div / 2;
        if (q >= 0) q = q / div;
        else        q = -((-q + div - 1) / div);
        clip = 1'b0;
        if (SAT) begin
            if (q > hi) begin q = hi; clip = 1'b1; end
            else if (q < lo) begin q = lo; clip = 1'b1; end
        end else begin
            q = q % span;
            if (q > hi) q = q - span;
            else if (q < lo) q = q + span;
        end
        return q;
    endfunction

    function automatic exp_t ref_mult(input FFT_DATA_SAMPLE a, input FFT_DATA_SAMPLE w);
        exp_t   e;
        bit     c_re, c_im;
        longint ar, ai, wr, wi;
        ar = $signed(a.data_r);
        ai = $signed(a.data_i);
        wr = $signed(w.data_r);
        wi = $signed(w.data_i);
        e.d.data_r = 16'(scale(ar * wr - ai * wi, c_re));
        e.d.data_i = 16'(scale(ar * wi + ai * wr, c_im));
        e.clip     = c_re | c_im;
        return e;
    endfunction

    // Scoreboard / protocol monitor, sampled on the falling edge
    exp_t           exp_q[$];
    int             acc_cnt  = 0;
    int             pop_cnt  = 0;
    int             out_cnt  = 0;
    bit             ovf_hist = 1'b0;
    bit             stalled  = 1'b0;
    FFT_DATA_SAMPLE held;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_cnt  = 0;
            ovf_hist = 1'b0;
            stalled  = 1'b0;
        end else begin
            check("in_ready", bus.in_ready, bus.out_ready || !bus.out_valid);
            check("tw_pop", bus.tw_pop, bus.in_valid && bus.in_ready);
            if (bus.tw_pop) pop_cnt++;
            if (stalled) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_r", bus.out_data.data_r, held.data_r);
                check("hold_i", bus.out_data.data_i, held.data_i);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", bus.out_valid, 0);
                end else begin
                    check("out_r", bus.out_data.data_r, exp_q[0].d.data_r);
                    check("out_i", bus.out_data.data_i, exp_q[0].d.data_i);
                    check("ovf", bus.ovf, SAT && (ovf_hist || exp_q[0].clip));
                    if (bus.out_ready) begin
                        ovf_hist = ovf_hist | exp_q[0].clip;
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end
                end
            end else begin
                check("ovf_idle", bus.ovf, SAT && ovf_hist);
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mult(bus.in_data,
                                         use_gen ? TW_TABLE[acc_cnt % TW_N] : tw_direct));
                acc_cnt++;
            end
        end
    end

    // One directed sample through an empty pipeline, checking exact latency
    task automatic run_one(input string tag, input int ar, input int ai, input int wr, input int wi,
                           input int er, input int ei);
        int p0;
        use_gen          = 1'b0;
        tw_direct.data_r = 16'(wr);
        tw_direct.data_i = 16'(wi);
        bus.out_ready    = 1'b1;
        bus.in_data.data_r = 16'(ar);
        bus.in_data.data_i = 16'(ai);
        bus.in_valid     = 1'b1;
        p0               = pop_cnt;
        @(negedge clk);
        check({tag, "_accept"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk); check({tag, "_lat1"}, bus.out_valid, 0);
        @(negedge clk); check({tag, "_lat2"}, bus.out_valid, 0);
        @(negedge clk); check({tag, "_lat3"}, bus.out_valid, 1);
        check({tag, "_re"}, bus.out_data.data_r, er);
        check({tag, "_im"}, bus.out_data.data_i, ei);
        check({tag, "_pops"}, pop_cnt - p0, 1);
        @(posedge clk); #1;
    endtask

    task automatic new_sample(input bit gen);
        bus.in_data.data_r = 16'($urandom_range(0, 65535));
        bus.in_data.data_i = 16'($urandom_range(0, 65535));
        if (!gen) begin
            tw_direct.data_r = 16'($urandom_range(0, 65535));
            tw_direct.data_i = 16'($urandom_range(0, 65535));
        end
    endtask

    // Stream n samples; rnd=0: in_valid held high, out_ready pattern 0,0,1
    task automatic stream(input string tag, input int n, input bit gen, input bit rnd);
        int sent, c, o0, p0;
        bit acc;
        sent    = 0;
        c       = 0;
        o0      = out_cnt;
        p0      = pop_cnt;
        use_gen = gen;
        new_sample(gen);
        bus.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        while ((sent < n || out_cnt - o0 < n) && c < 400) begin
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : (c % 3 == 2);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            if (sent >= n) begin
                bus.in_valid = 1'b0;
            end else if (acc || !bus.in_valid) begin
                new_sample(gen);
                bus.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            c++;
        end
        bus.out_ready = 1'b1;
        check({tag, "_outs"}, out_cnt - o0, n);
        check({tag, "_pops"}, pop_cnt - p0, n);
        check({tag, "_left"}, exp_q.size(), 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_vld"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_ovf"}, bus.ovf, 0);
        check({tag, "_rdy"}, bus.in_ready, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        tw_direct     = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_vld", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_rdy", bus.in_ready, 1);
        check("rst_pop", bus.tw_pop, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_one("ident", 1000, -2000, 16384, 0, 1000, -2000);
        run_one("negj", 1000, -2000, 0, -16384, -2000, -1000);
        run_one("rnd_pos", 3, 0, 8192, 0, 2, 0);
        run_one("rnd_neg", -3, 0, 8192, 0, -1, 0);
        check("ovf_before", bus.ovf, 0);
        // Real part: raw product -11585 rounds to -1; imaginary is out of range
`ifdef FFT_MULT_SAT_EN
        run_one("ovf_case", -32768, 32767, 11585, -11585, -1, 32767);
        check("ovf_set", bus.ovf, 1);
`else
        run_one("ovf_case", -32768, 32767, 11585, -11585, -1, -19197);
        check("ovf_set", bus.ovf, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("ovf_sticky", bus.ovf, SAT);

        // Reset restarts the generator order at index 0
        pulse_reset("rst1");
        stream("bp", 8, 1'b1, 1'b0);
        stream("rand", 40, 1'b0, 1'b1);

        // Mid-stream reset with three samples in flight
        use_gen       = 1'b1;
        bus.out_ready = 1'b1;
        new_sample(1'b1);
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
            new_sample(1'b1);
        end
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", bus.out_valid, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_rdy", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", bus.out_valid, 0);
        stream("post_rst", 1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("final_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
